// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and reset constants.
package instruction_fetch_pkg;

    // Fetch FSM: no request, request outstanding, one fetched word parked in skid.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SKID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding imem request, registered output slot,
// one-entry skid buffer so an ack under a downstream stall is never lost, and
// redirect handling that squashes wrong-path words (including in-flight ones).
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction32,
    output logic [31:0] pc_out,
    output logic        inst_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic         skid_vld_q, skid_vld_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_pc_q, pend_pc_d;

    logic         slot_free;
    logic [31:0]  tgt;

    assign slot_free = !valid_q || !stall;
    assign tgt       = redirect_pc & ~32'h3;

    assign imem_req      = (state_q == ST_REQ);
    assign imem_addr     = pc_q;
    assign Instruction32 = instr_q;
    assign pc_out        = pc_out_q;
    assign inst_valid    = valid_q;

    // Next-state: consumption first, then redirect (highest priority) or per-state action.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_vld_d   = skid_vld_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;

        // Output consumed (or empty): show a bubble unless something is loaded below.
        if (slot_free) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        if (redirect) begin
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            skid_vld_d = 1'b0;
            if (state_q == ST_REQ && !imem_ack) begin
                // Request still in flight: it cannot be withdrawn, so remember the
                // target and drop whatever comes back.
                pend_d    = 1'b1;
                pend_pc_d = tgt;
            end else begin
                pc_d    = tgt;
                pend_d  = 1'b0;
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (slot_free) state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        if (pend_q) begin
                            pc_d   = pend_pc_q;
                            pend_d = 1'b0;
                        end else if (slot_free) begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                            pc_d     = pc_q + 32'd4;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_q;
                            skid_vld_d   = 1'b1;
                            pc_d         = pc_q + 32'd4;
                            state_d      = ST_SKID;
                        end
                    end
                end
                ST_SKID: begin
                    if (!stall && skid_vld_q) begin
                        instr_d    = skid_instr_q;
                        pc_out_d   = skid_pc_q;
                        valid_d    = 1'b1;
                        skid_vld_d = 1'b0;
                        state_d    = ST_REQ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= 32'h0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_vld_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_vld_q   <= skid_vld_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule
